// File: rtl/brom_scan_ctrl_if.sv
// Request/result and ROM read bus for brom_scan_ctrl.
// The BROM_SCAN_MIN_EN macro adds the min_val/min_addr result fields.
interface brom_scan_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              busy;
    logic              done;
    logic              found;
    logic [DATA_W-1:0] max_val;
    logic [ADDR_W-1:0] max_addr;
`ifdef BROM_SCAN_MIN_EN
    logic [DATA_W-1:0] min_val;
    logic [ADDR_W-1:0] min_addr;
`endif

    // slave is the sequencer, master is whoever drives requests and models the ROM
    modport slave (
        input  start, base_addr, len, rom_dout,
        output rom_en, rom_addr, busy, done, found, max_val, max_addr
`ifdef BROM_SCAN_MIN_EN
        , min_val, min_addr
`endif
    );

    modport master (
        output start, base_addr, len, rom_dout,
        input  rom_en, rom_addr, busy, done, found, max_val, max_addr
`ifdef BROM_SCAN_MIN_EN
        , min_val, min_addr
`endif
    );
endinterface

// File: rtl/brom_scan_ctrl.sv
// Block-ROM window scanner: issues one read per cycle, tracks reads through the
// BRAM latency and reports the max word/address. BROM_SCAN_MIN_EN adds min tracking.
module brom_scan_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    brom_scan_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

    state_e                         state_q, state_d;
    logic                           rom_en_q, rom_en_d;
    logic [ADDR_W-1:0]              rom_addr_q, rom_addr_d;
    logic [ADDR_W:0]                rem_q, rem_d;
    logic [RD_LAT-1:0]              vld_q, vld_d;
    logic [RD_LAT-1:0][ADDR_W-1:0]  tag_q, tag_d;
    logic                           found_q, found_d;
    logic [DATA_W-1:0]              max_val_q, max_val_d;
    logic [ADDR_W-1:0]              max_addr_q, max_addr_d;
`ifdef BROM_SCAN_MIN_EN
    logic [DATA_W-1:0]              min_val_q, min_val_d;
    logic [ADDR_W-1:0]              min_addr_q, min_addr_d;
`endif

    always_comb begin
        state_d    = state_q;
        rom_en_d   = rom_en_q;
        rom_addr_d = rom_addr_q;
        rem_d      = rem_q;
        found_d    = found_q;
        max_val_d  = max_val_q;
        max_addr_d = max_addr_q;
`ifdef BROM_SCAN_MIN_EN
        min_val_d  = min_val_q;
        min_addr_d = min_addr_q;
`endif
        // each issued read carries its address until the data appears on rom_dout
        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = rom_en_q;
        tag_d[0] = rom_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        if (vld_q[RD_LAT-1]) begin
            found_d = 1'b1;
            if (!found_q || bus.rom_dout > max_val_q) begin
                max_val_d  = bus.rom_dout;
                max_addr_d = tag_q[RD_LAT-1];
            end
`ifdef BROM_SCAN_MIN_EN
            if (!found_q || bus.rom_dout < min_val_q) begin
                min_val_d  = bus.rom_dout;
                min_addr_d = tag_q[RD_LAT-1];
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    found_d    = 1'b0;
                    max_val_d  = '0;
                    max_addr_d = '0;
`ifdef BROM_SCAN_MIN_EN
                    min_val_d  = '0;
                    min_addr_d = '0;
`endif
                    rem_d = bus.len - 1'b1;
                    if (bus.len != '0) begin
                        state_d    = ISSUE;
                        rom_en_d   = 1'b1;
                        rom_addr_d = bus.base_addr;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            ISSUE: begin
                if (rem_q == '0) begin
                    rom_en_d = 1'b0;
                    state_d  = DRAIN;
                end else begin
                    rom_addr_d = rom_addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                end
            end
            // the oldest entry compares on this edge, so leave once nothing younger remains
            DRAIN:   if (vld_d == '0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rem_q      <= '0;
            vld_q      <= '0;
            tag_q      <= '0;
            found_q    <= 1'b0;
            max_val_q  <= '0;
            max_addr_q <= '0;
`ifdef BROM_SCAN_MIN_EN
            min_val_q  <= '0;
            min_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rem_q      <= rem_d;
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            found_q    <= found_d;
            max_val_q  <= max_val_d;
            max_addr_q <= max_addr_d;
`ifdef BROM_SCAN_MIN_EN
            min_val_q  <= min_val_d;
            min_addr_q <= min_addr_d;
`endif
        end
    end

    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done     = (state_q == FIN);
    assign bus.found    = found_q;
    assign bus.max_val  = max_val_q;
    assign bus.max_addr = max_addr_q;
`ifdef BROM_SCAN_MIN_EN
    assign bus.min_val  = min_val_q;
    assign bus.min_addr = min_addr_q;
`endif
endmodule
